// File: rtl/lzd_norm_scheduler_pkg.sv
// Shared types and helpers for the normalisation scheduler.
// Holds the two legal mantissa widths, per-width operand records, the
// saturating exponent subtract and a leading-zero counter sized for the
// widest (double) mantissa.
package lzd_norm_scheduler_pkg;

  localparam int LZD_W_DP  = 53;
  localparam int LZD_W_HB  = 24;
  localparam int EXP_W_MAX = 11;
  localparam int LZ_W      = 6;   // holds 0..53

  typedef struct packed {
    logic [LZD_W_HB-1:0] mant;
    logic [7:0]          exp;
    logic [2:0]          id;
  } norm_op_hb_t;

  typedef struct packed {
    logic [LZD_W_DP-1:0] mant;
    logic [10:0]         exp;
    logic [2:0]          id;
  } norm_op_dp_t;

  // Exponent adjust that clamps at zero instead of wrapping.
  function automatic logic [EXP_W_MAX-1:0] sat_sub(input logic [EXP_W_MAX-1:0] a,
                                                    input logic [EXP_W_MAX-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  // Leading zeros of the low w bits of v; returns w for an all-zero value.
  function automatic logic [LZ_W-1:0] lead_zeros(input logic [LZD_W_DP-1:0] v,
                                                  input int w);
    logic [LZ_W-1:0] cnt;
    logic            found;
    cnt   = '0;
    found = 1'b0;
    for (int i = LZD_W_DP - 1; i >= 0; i--) begin
      if (i < w && !found) begin
        if (v[i]) found = 1'b1;
        else      cnt   = cnt + LZ_W'(1);
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lzd_norm_scheduler_rr_arbiter.sv
// Round-robin arbiter for the normalisation scheduler.
// Ports: req (request vector), advance (a grant was taken this cycle),
// grant (one-hot or zero), gidx (index of the granted requester).
// The priority pointer moves to one past the winner only when advance is set.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] gidx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/lzd_norm_scheduler.sv
// Shared leading-zero-detect + normalise datapath for N_REQ requesters.
// Stage 1 arbitrates round-robin and registers the winning operand;
// stage 2 counts leading zeros, shifts and adjusts the exponent.
// Ports: req_valid/req_ready/req_mant/req_exp (per-requester operands,
// packed i*WIDTH / i*EXP_W), out_valid/out_ready (result handshake),
// out_id/out_mant/out_exp/out_zero/out_uflow (tagged normalised result).
module lzd_norm_scheduler
  import lzd_norm_scheduler_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 24,
  parameter  int EXP_W = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_mant,
  input  logic [N_REQ*EXP_W-1:0] req_exp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_id,
  output logic [WIDTH-1:0]       out_mant,
  output logic [EXP_W-1:0]       out_exp,
  output logic                   out_zero,
  output logic                   out_uflow
);

  if (!(WIDTH == LZD_W_HB || WIDTH == LZD_W_DP) || N_REQ < 2 || N_REQ > 8) begin : g_bad_cfg
    $error("lzd_norm_scheduler: WIDTH must be 24 or 53 and N_REQ 2..8");
  end

  logic             run;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_mant;
  logic [EXP_W-1:0] s1_exp;
  logic [ID_W-1:0]  s1_id;
  logic             s1_acc, s2_acc, xfer;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gidx;

  logic [LZ_W-1:0]  lz, sh;
  logic             is_zero, uflow;
  logic [WIDTH-1:0] norm_mant;
  logic [EXP_W-1:0] norm_exp;

  assign s2_acc    = !out_valid || out_ready;
  assign s1_acc    = !s1_valid || s2_acc;
  // run keeps req_ready low while reset is held and for the release edge.
  assign req_ready = grant & {N_REQ{s1_acc & run}};
  assign xfer      = |req_ready;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (xfer),
    .grant   (grant),
    .gidx    (gidx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_id    <= '0;
    end else begin
      run <= 1'b1;
      if (s1_acc) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_mant <= req_mant[gidx*WIDTH +: WIDTH];
          s1_exp  <= req_exp[gidx*EXP_W +: EXP_W];
          s1_id   <= gidx;
        end
      end
    end
  end

  // The shift is capped by the exponent so a small exponent yields a
  // subnormal (exp 0) rather than wrapping below zero.
  always_comb begin
    lz        = lead_zeros(LZD_W_DP'(s1_mant), WIDTH);
    is_zero   = (s1_mant == '0);
    uflow     = !is_zero && (EXP_W_MAX'(s1_exp) < EXP_W_MAX'(lz));
    sh        = uflow ? LZ_W'(s1_exp) : lz;
    norm_mant = s1_mant << sh;
    norm_exp  = is_zero ? '0 : EXP_W'(sat_sub(EXP_W_MAX'(s1_exp), EXP_W_MAX'(lz)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else if (s2_acc) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_id    <= s1_id;
        out_mant  <= norm_mant;
        out_exp   <= norm_exp;
        out_zero  <= is_zero;
        out_uflow <= uflow;
      end
    end
  end

endmodule

// File: tb/tb_lzd_norm_scheduler.sv
`timescale 1ns/1ps
module tb_lzd_norm_scheduler;

  localparam int N = 4;
  localparam int W = 24;
  localparam int E = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_mant;
  logic [N*E-1:0] req_exp;
  logic           out_valid, out_ready;
  logic [1:0]     out_id;
  logic [W-1:0]   out_mant;
  logic [E-1:0]   out_exp;
  logic           out_zero, out_uflow;

  logic [1:0]     d_valid, d_ready;
  logic [105:0]   d_mant;
  logic [21:0]    d_exp;
  logic           d_ovalid;
  logic           d_oready;
  logic           d_oid;
  logic [52:0]    d_omant;
  logic [10:0]    d_oexp;
  logic           d_ozero, d_ouflow;

  always #5 clk = ~clk;

  lzd_norm_scheduler #(.N_REQ(N), .WIDTH(W), .EXP_W(E)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mant(req_mant), .req_exp(req_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_mant(out_mant),
    .out_exp(out_exp), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  lzd_norm_scheduler #(.N_REQ(2), .WIDTH(53), .EXP_W(11)) dut53 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d_valid), .req_ready(d_ready), .req_mant(d_mant), .req_exp(d_exp),
    .out_valid(d_ovalid), .out_ready(d_oready), .out_id(d_oid), .out_mant(d_omant),
    .out_exp(d_oexp), .out_zero(d_ozero), .out_uflow(d_ouflow)
  );

  typedef struct { logic [W-1:0] mant; logic [E-1:0] exp; } op_t;
  typedef struct {
    logic [1:0] id; logic [W-1:0] mant; logic [E-1:0] exp; logic zero; logic uflow; bit lat;
  } res_t;
  typedef struct { logic [52:0] mant; logic [10:0] exp; logic zero; logic uflow; } res53_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sustain = 1'b0;
  logic [N-1:0] pend = '0;

  op_t    req_q [N][$];
  res_t   exp_q [$];
  int     acc_q [$];
  res53_t q53   [$];

  res_t   mon_e;
  int     mon_a;
  res53_t mon_e53;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic add_op(input int i, input logic [W-1:0] m, input logic [E-1:0] x);
    op_t o;
    o.mant = m;
    o.exp  = x;
    req_q[i].push_back(o);
  endtask

  task automatic expect_res(input logic [1:0] id, input logic [W-1:0] m, input logic [E-1:0] x,
                            input logic z, input logic u, input bit lat);
    res_t r;
    r.id = id; r.mant = m; r.exp = x; r.zero = z; r.uflow = u; r.lat = lat;
    exp_q.push_back(r);
  endtask

  function automatic bit busy();
    bit b;
    b = (exp_q.size() != 0);
    for (int i = 0; i < N; i++) if (req_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s_drain: %0d results still pending after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
    @(posedge clk);
    #1;
  endtask

  // requester model: hold each operand until the cycle it is accepted
  initial begin
    req_valid = '0;
    req_mant  = '0;
    req_exp   = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        if (req_q[i].size() > 0) begin
          req_valid[i]     = 1'b1;
          req_mant[i*W +: W] = req_q[i][0].mant;
          req_exp[i*E +: E]  = req_q[i][0].exp;
        end else begin
          req_valid[i]     = 1'b0;
          req_mant[i*W +: W] = '0;
          req_exp[i*E +: E]  = '0;
        end
      end
    end
  end

  // handshake observer: accepts, one-hot grant, no bubbles while streaming
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      pend = req_valid & req_ready;
      checks++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
        errors++;
        $display("FAIL grant_onehot: req_ready=%b req_valid=%b, required one-hot subset", req_ready, req_valid);
      end
      if (pend != '0) acc_q.push_back(cyc + 1);
      if (sustain && out_ready && req_valid != '0) begin
        checks++;
        if (req_ready == '0) begin
          errors++;
          $display("FAIL no_bubble: req_ready=%b with req_valid=%b, required a grant", req_ready, req_valid);
        end
      end
    end else begin
      pend = '0;
    end
  end

  // result monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: id=%0d mant=%h exp=%0d, required no result", out_id, out_mant, out_exp);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
        if (out_id !== mon_e.id || out_mant !== mon_e.mant || out_exp !== mon_e.exp ||
            out_zero !== mon_e.zero || out_uflow !== mon_e.uflow) begin
          errors++;
          $display("FAIL result: got id=%0d mant=%h exp=%0d zero=%b uflow=%b, required id=%0d mant=%h exp=%0d zero=%b uflow=%b",
                   out_id, out_mant, out_exp, out_zero, out_uflow,
                   mon_e.id, mon_e.mant, mon_e.exp, mon_e.zero, mon_e.uflow);
        end
        if (mon_e.lat) begin
          checks++;
          if (cyc + 1 - mon_a != 2) begin
            errors++;
            $display("FAIL latency: got %0d edges, required 2", cyc + 1 - mon_a);
          end
        end
      end
    end
  end

  // double-width instance monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && d_ovalid && d_oready) begin
      checks++;
      if (q53.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result53: mant=%h exp=%0d, required no result", d_omant, d_oexp);
      end else begin
        mon_e53 = q53.pop_front();
        if (d_oid !== 1'b0 || d_omant !== mon_e53.mant || d_oexp !== mon_e53.exp ||
            d_ozero !== mon_e53.zero || d_ouflow !== mon_e53.uflow) begin
          errors++;
          $display("FAIL result53: got id=%0d mant=%h exp=%0d zero=%b uflow=%b, required id=0 mant=%h exp=%0d zero=%b uflow=%b",
                   d_oid, d_omant, d_oexp, d_ozero, d_ouflow,
                   mon_e53.mant, mon_e53.exp, mon_e53.zero, mon_e53.uflow);
        end
      end
    end
  end

  task automatic op53(input logic [52:0] m, input logic [10:0] x,
                      input logic [52:0] em, input logic [10:0] ex, input logic z, input logic u);
    res53_t r;
    int n;
    r.mant = em; r.exp = ex; r.zero = z; r.uflow = u;
    q53.push_back(r);
    d_valid[0]     = 1'b1;
    d_mant[52:0]   = m;
    d_exp[10:0]    = x;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ready[0] && n < 10);
    chk("accept53", d_ready[0], 1'b1);
    @(posedge clk);
    #1;
    d_valid[0] = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    out_ready = 1'b1;
    d_valid   = '0;
    d_mant    = '0;
    d_exp     = '0;
    d_oready  = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_mant", out_mant, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_uflow", out_uflow, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single operand, latency 2
    sustain = 1'b1;
    expect_res(2'd0, 24'hF00000, 8'd8, 1'b0, 1'b0, 1'b1);
    add_op(0, 24'h000F00, 8'd20);
    wait_drain("single", 20);

    // all four streaming; pointer sits at 1 after the single transfer
    add_op(0, 24'h800000, 8'd10);  add_op(0, 24'h123456, 8'd3);
    add_op(1, 24'h400000, 8'd10);  add_op(1, 24'h000001, 8'd5);
    add_op(2, 24'h00FFFF, 8'd50);  add_op(2, 24'h000000, 8'd100);
    add_op(3, 24'h000003, 8'd100); add_op(3, 24'hFFFFFF, 8'd0);
    expect_res(2'd1, 24'h800000, 8'd9,  1'b0, 1'b0, 1'b1);
    expect_res(2'd2, 24'hFFFF00, 8'd42, 1'b0, 1'b0, 1'b1);
    expect_res(2'd3, 24'hC00000, 8'd78, 1'b0, 1'b0, 1'b1);
    expect_res(2'd0, 24'h800000, 8'd10, 1'b0, 1'b0, 1'b1);
    expect_res(2'd1, 24'h000020, 8'd0,  1'b0, 1'b1, 1'b1);
    expect_res(2'd2, 24'h000000, 8'd0,  1'b1, 1'b0, 1'b1);
    expect_res(2'd3, 24'hFFFFFF, 8'd0,  1'b0, 1'b0, 1'b1);
    expect_res(2'd0, 24'h91A2B0, 8'd0,  1'b0, 1'b0, 1'b1);
    wait_drain("stream", 40);
    sustain = 1'b0;

    // backpressure with four pending; pointer at 1
    out_ready = 1'b0;
    add_op(0, 24'h000100, 8'd200);
    add_op(1, 24'h0F0000, 8'd7);
    add_op(2, 24'h000080, 8'd16);
    add_op(3, 24'h000080, 8'd15);
    expect_res(2'd1, 24'hF00000, 8'd3,   1'b0, 1'b0, 1'b0);
    expect_res(2'd2, 24'h800000, 8'd0,   1'b0, 1'b0, 1'b0);
    expect_res(2'd3, 24'h400000, 8'd0,   1'b0, 1'b1, 1'b0);
    expect_res(2'd0, 24'h800000, 8'd185, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_id", out_id, 1);
      chk("stall_out_mant", out_mant, 24'hF00000);
      chk("stall_out_exp", out_exp, 3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("backpressure", 40);

    // reset mid-stream with a full pipeline
    out_ready = 1'b0;
    add_op(0, 24'h0000AA, 8'd40);
    add_op(1, 24'h00BB00, 8'd40);
    add_op(2, 24'h0C0000, 8'd40);
    add_op(3, 24'h000D00, 8'd40);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("reset_async_out_valid", out_valid, 0);
    for (int i = 0; i < N; i++) req_q[i].delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    add_op(2, 24'h00000F, 8'd30);
    add_op(3, 24'h7FFFFF, 8'd1);
    expect_res(2'd2, 24'hF00000, 8'd10, 1'b0, 1'b0, 1'b1);
    expect_res(2'd3, 24'hFFFFFE, 8'd0,  1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (req_ready != '0) break;
      n++;
    end
    chk("first_grant_after_reset", req_ready, 4'b0100);
    wait_drain("after_reset", 30);

    // double-width instance
    op53(53'h1, 11'd1000, 53'h10000000000000, 11'd948, 1'b0, 1'b0);
    op53(53'h10000000000000, 11'd0, 53'h10000000000000, 11'd0, 1'b0, 1'b0);
    op53(53'h1, 11'd10, 53'h400, 11'd0, 1'b0, 1'b1);
    op53(53'h0, 11'd5, 53'h0, 11'd0, 1'b1, 1'b0);
    n = 0;
    while (q53.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("drain53", q53.size(), 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
